// File: rtl/bs_rbtr_multimode.sv
// Shared-bus arbiter: pulls one packet at a time from the pending device FIFOs
// (fixed priority or round-robin) and delivers it by unicast or broadcast.
module bs_rbtr_multimode #(
   parameter int         pckg_sz   = 32,
   parameter int         drvrs     = 4,
   parameter logic [7:0] broadcast = 8'hFF
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [drvrs-1:0]                 pndng,
   input  logic [drvrs-1:0][pckg_sz-1:0]    D_pop,
   input  logic [drvrs-1:0]                 full,
   input  logic                             mode,
   output logic [drvrs-1:0]                 pop,
   output logic [drvrs-1:0]                 push,
   output logic [drvrs-1:0][pckg_sz-1:0]    D_push,
   output logic                             busy,
   output logic [31:0]                      pkt_cnt,
   output logic [15:0]                      drop_cnt,
   output logic [1:0]                       state_dbg
);

   // Handshakes: a source offers a packet while pndng[i]=1 with D_pop[i] valid;
   // it is consumed by the one-cycle pop[i] strobe. A sink accepts push[i] only
   // when full[i]=0, and every target of a packet is pushed in the same cycle.

   localparam int IW = (drvrs > 2) ? $clog2(drvrs) : 1;
   localparam logic [drvrs-1:0] ONE = {{(drvrs-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      POP  = 2'd1,
      PUSH = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic                done_q, done_d;
   logic [IW-1:0]       win_q, win_d;
   logic [IW-1:0]       last_q, last_d;
   logic [pckg_sz-1:0]  pkt_q, pkt_d;
   logic [drvrs-1:0]    pop_d, push_d;
   logic                busy_d;
   logic [31:0]         pkt_cnt_d;
   logic [15:0]         drop_cnt_d;

   logic [IW-1:0]       win_sel;
   logic [IW-1:0]       rr_idx;
   int                  rr_sum;
   logic                grant_any;

   logic [7:0]          dest;
   logic                is_uni, is_bcast, is_self, invalid, ready;
   logic [drvrs-1:0]    targets;

   assign state_dbg = state_q;
   assign grant_any = |pndng;

   // Winner selection; the last assignment in each loop has highest priority.
   always_comb begin
      win_sel = '0;
      rr_idx  = '0;
      rr_sum  = 0;
      if (mode) begin
         for (int off = drvrs; off >= 1; off--) begin
            rr_sum = int'(last_q) + off;
            if (rr_sum >= drvrs) rr_sum = rr_sum - drvrs;
            rr_idx = IW'(rr_sum);
            if (pndng[rr_idx]) win_sel = rr_idx;
         end
      end else begin
         for (int i = drvrs - 1; i >= 0; i--) begin
            if (pndng[IW'(i)]) win_sel = IW'(i);
         end
      end
   end

   assign dest     = pkt_q[pckg_sz-1 -: 8];
   assign is_uni   = (int'(dest) < drvrs);
   assign is_bcast = (dest == broadcast);
   assign is_self  = (int'(dest) == int'(win_q));
   assign invalid  = is_uni ? is_self : !is_bcast;
   assign ready    = ((targets & full) == '0);

   for (genvar g = 0; g < drvrs; g++) begin : g_lane
      assign targets[g] = is_uni ? (int'(dest) == g)
                                 : (is_bcast && (int'(win_q) != g));
      assign D_push[g]  = pkt_q;
   end

   always_comb begin
      state_d    = state_q;
      done_d     = done_q;
      win_d      = win_q;
      last_d     = last_q;
      pkt_d      = pkt_q;
      pop_d      = '0;
      push_d     = '0;
      pkt_cnt_d  = pkt_cnt;
      drop_cnt_d = drop_cnt;
      case (state_q)
         IDLE: begin
            if (grant_any) begin
               win_d   = win_sel;
               last_d  = win_sel;
               pkt_d   = D_pop[win_sel];
               pop_d   = ONE << win_sel;
               done_d  = 1'b0;
               state_d = POP;
            end
         end
         POP, PUSH: begin
            // done_q marks the single PUSH cycle that follows a push or a drop.
            if (state_q == PUSH && done_q) begin
               state_d = IDLE;
            end else begin
               state_d = PUSH;
               if (invalid) begin
                  if (drop_cnt != 16'hFFFF) drop_cnt_d = drop_cnt + 16'd1;
                  done_d = 1'b1;
               end else if (ready) begin
                  push_d    = targets;
                  pkt_cnt_d = pkt_cnt + 32'd1;
                  done_d    = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         done_q   <= 1'b0;
         win_q    <= '0;
         last_q   <= IW'(drvrs - 1);
         pkt_q    <= '0;
         pop      <= '0;
         push     <= '0;
         busy     <= 1'b0;
         pkt_cnt  <= '0;
         drop_cnt <= '0;
      end else begin
         state_q  <= state_d;
         done_q   <= done_d;
         win_q    <= win_d;
         last_q   <= last_d;
         pkt_q    <= pkt_d;
         pop      <= pop_d;
         push     <= push_d;
         busy     <= busy_d;
         pkt_cnt  <= pkt_cnt_d;
         drop_cnt <= drop_cnt_d;
      end
   end

endmodule
